fifo_byte_drain: RTL and testbench
==================================

Name: fifo_byte_drain

Overview:
Downstream consumer of the 32-bit FIFO (fifo_mem). It drains words from the FIFO and serialises each word into four bytes, MSB first, onto a valid/ready byte stream that feeds the byte-wide crypto/UART path. It asserts the FIFO's rd strobe only when it can accept a word, counts the words it drains, and latches FIFO underflow as a sticky error.

Parameters:
DATA_W, 32, FIFO word width; must be a multiple of 8.
NBYTES, DATA_W/8, bytes per word (derived; do not override).
CNT_W, 16, width of word_count.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
enable  input  1  permits new FIFO reads; a word already in progress always completes
fifo_rd  output  1  read strobe to FIFO rd; combinational
fifo_data_out  input  DATA_W  FIFO head word; show-ahead, valid whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_underflow  input  1  FIFO underflow flag
byte_data  output  8  current output byte
byte_valid  output  1  byte_data valid
byte_ready  input  1  sink accepts byte
byte_last  output  1  marks last byte of a word
word_count  output  CNT_W  words read from FIFO since reset; wraps
err_underflow  output  1  sticky underflow error

Behaviour:
- Reset: one clk and one reset, synchronous active-low, named clk and rst_n. On a rising edge with rst_n=0: state=IDLE, byte index=0, shift register=0, byte_valid=0, byte_last=0, byte_data=0, word_count=0, err_underflow=0. fifo_rd is gated by rst_n, so it is 0 throughout reset.
- Handshake: a beat transfers on a rising edge with byte_valid=1 and byte_ready=1. While byte_valid=1 and byte_ready=0, byte_data and byte_last hold stable. byte_valid never depends on byte_ready.
- FSM states: IDLE and SEND.
- IDLE:
  - fifo_rd = enable & ~fifo_empty.
  - On the edge where fifo_rd=1: capture fifo_data_out into the shift register, set index=0, go to SEND.
  - byte_valid=0 in IDLE.
- SEND:
  - byte_valid=1; byte_data = shift[DATA_W-1 -: 8]; byte_last = (index==NBYTES-1).
  - On a beat with index<NBYTES-1: shift left by 8 and increment index.
  - On a beat with index==NBYTES-1, if enable & ~fifo_empty: fifo_rd=1 that cycle, load the next word, index=0, stay in SEND. This gives back-to-back words with no bubble.
  - On a beat with index==NBYTES-1 otherwise: go to IDLE; byte_valid=0 on the next cycle.
  - fifo_rd=0 in SEND except on that final beat.
- fifo_rd is a single-cycle strobe per word and is never asserted while fifo_empty=1. The block therefore never causes an underflow itself.
- word_count increments by 1 on every edge where fifo_rd=1. It is modulo 2^CNT_W (0xFFFF -> 0x0000).
- err_underflow is set on any edge with fifo_underflow=1 and cleared only by reset.
- enable falling mid-word: the remaining bytes of that word are sent, then the FSM goes to IDLE. enable has no effect on a beat already presented.
- fifo_empty rising while in SEND: the current word is unaffected, since it is held in the shift register.
- rst_n low mid-word: the partial word is discarded; no further bytes of it are emitted after reset.
- Latency: the first byte is valid on the cycle after the fifo_rd edge. Sustained throughput is 1 byte/clk with byte_ready=1, i.e. one FIFO read every NBYTES cycles.

Test Plan:
- FIFO holds 0xDEADBEEF, enable=1, byte_ready=1 -> exactly one fifo_rd pulse. Bytes DE, AD, BE, EF appear on 4 consecutive cycles, byte_last=1 only with EF. Then byte_valid=0 and word_count=1.
- Backpressure: same word, byte_ready low for 3 cycles while 0xAD is presented -> byte_data holds 0xAD and byte_valid stays 1. No extra fifo_rd; the sequence completes DE, AD, BE, EF.
- Back-to-back: FIFO holds 0xCAFEBABE then 0x12345678, byte_ready=1 -> 8 consecutive beats CA FE BA BE 12 34 56 78 with no bubble. fifo_rd pulses on cycle 0 and on the BE beat; byte_last on BE and 78; word_count=2.
- enable dropped after the first beat of 0xCAFEBABE with a second word queued -> FE, BA, BE still sent, then IDLE with no second fifo_rd. Re-asserting enable resumes with the next word.
- rst_n=0 for one cycle while 0xBA is presented -> next cycle byte_valid=0, word_count=0, err_underflow=0; no remaining bytes of that word emitted.
- fifo_underflow pulsed high for 1 cycle -> err_underflow=1 and stays 1 through later traffic until rst_n=0.

Source files
------------

// File: rtl/fifo_byte_drain.sv
// -----------------------------------------------------------------------------
// fifo_byte_drain
//
// Drains DATA_W-bit words from a show-ahead FIFO and serialises each word onto
// a valid/ready byte stream, most significant byte first. A new word is read
// only when the block can start sending it. Reads are chained onto the final
// beat of the previous word, so a steady stream of words leaves no bubble.
// The block also counts words read and keeps a sticky FIFO-underflow error.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   enable         in   permits new FIFO reads; a word in progress completes
//   fifo_rd        out  single-cycle FIFO read strobe (combinational)
//   fifo_data_out  in   FIFO head word, valid whenever fifo_empty = 0
//   fifo_empty     in   FIFO empty flag
//   fifo_underflow in   FIFO underflow flag
//   byte_data      out  current output byte
//   byte_valid     out  byte_data valid
//   byte_ready     in   sink accepts byte
//   byte_last      out  last byte of the current word
//   word_count     out  words read since reset, wraps modulo 2^CNT_W
//   err_underflow  out  sticky underflow error, cleared only by reset
// -----------------------------------------------------------------------------
module fifo_byte_drain #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              fifo_empty,
    input  logic              fifo_underflow,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic [CNT_W-1:0]  word_count,
    output logic              err_underflow
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  word_count_q;
    logic              err_q;

    logic beat;
    logic last_beat;

    assign beat      = (state_q == ST_SEND) & byte_ready;
    assign last_beat = beat & (idx_q == LAST_IDX);

    // A read is allowed from IDLE, or on the final beat of the current word so
    // the next word follows without a gap. Gating with rst_n keeps the strobe
    // low while reset is held, even if the FSM registers are not yet cleared.
    assign fifo_rd = rst_n & enable & ~fifo_empty &
                     ((state_q == ST_IDLE) | last_beat);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        if (fifo_rd) begin
            shift_d = fifo_data_out;
            idx_d   = '0;
            state_d = ST_SEND;
        end else if (beat) begin
            // After the final beat the register shifts to zero, so byte_data
            // reads 0 while idle.
            shift_d = shift_q << 8;
            if (idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            shift_q      <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            if (fifo_rd) begin
                word_count_q <= word_count_q + CNT_W'(1);
            end
            if (fifo_underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign byte_valid    = (state_q == ST_SEND);
    assign byte_data     = shift_q[DATA_W-1 -: 8];
    assign byte_last     = byte_valid & (idx_q == LAST_IDX);
    assign word_count    = word_count_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_byte_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_byte_drain
//
// Bench for fifo_byte_drain. A behavioural show-ahead FIFO feeds the DUT.
// Pushing a word into that FIFO also pushes its four expected bytes (and last
// flags) onto a scoreboard, which a negedge monitor pops on every accepted
// beat. Scenario tasks check strobe timing, stalls and counters inline.
// -----------------------------------------------------------------------------
module tb_fifo_byte_drain;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fifo_rd;
    logic [31:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic [15:0] word_count;
    logic        err_underflow;

    int total;
    int bad;

    logic [31:0] fifo_q[$];
    logic [7:0]  sb_data[$];
    bit          sb_last[$];
    bit          pop_pending;
    int          exp_wc;

    fifo_byte_drain #(.DATA_W(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_rd        (fifo_rd),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .byte_last      (byte_last),
        .word_count     (word_count),
        .err_underflow  (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the inputs are stable at the negedge, so the values seen here
    // are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (fifo_rd) begin
            total++;
            if (fifo_q.size() == 0) begin
                bad++;
                $display("FAIL rd_when_empty: fifo_rd=1 got, fifo_rd=0 required (FIFO empty)");
            end else begin
                pop_pending = 1'b1;
            end
        end
        if (byte_valid && byte_ready && rst_n) begin
            total++;
            if (sb_data.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: byte %02h got, no byte expected", byte_data);
            end else begin
                logic [7:0] ed;
                bit el;
                ed = sb_data.pop_front();
                el = sb_last.pop_front();
                if (byte_data !== ed || byte_last !== el) begin
                    bad++;
                    $display("FAIL beat: data=%02h last=%0b got, data=%02h last=%0b required",
                             byte_data, byte_last, ed, el);
                end else begin
                    $display("beat data=%02h last=%0b", byte_data, byte_last);
                end
            end
        end
    end

    task automatic refresh_fifo();
        fifo_empty    = (fifo_q.size() == 0);
        fifo_data_out = (fifo_q.size() == 0) ? 32'h0BAD_0BAD : fifo_q[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < 4; b++) begin
            sb_data.push_back(w[31 - 8*b -: 8]);
            sb_last.push_back(b == 3);
        end
        refresh_fifo();
    endtask

    // Advance across one rising edge; apply the FIFO pop it caused.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pending) begin
            void'(fifo_q.pop_front());
            exp_wc      = (exp_wc + 1) % 65536;
            pop_pending = 1'b0;
        end
        refresh_fifo();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        enable         = 1'b1;
        byte_ready     = 1'b1;
        fifo_underflow = 1'b0;
        push_word(32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (fifo_rd !== 1'b0) begin
                bad++;
                $display("FAIL reset_rd: fifo_rd=%0b got, 0 required", fifo_rd);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (byte_valid !== 1'b0 || byte_last !== 1'b0 || byte_data !== 8'h00 ||
            word_count !== 16'h0 || err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%0b last=%0b data=%02h wc=%0d err=%0b got, all 0 required",
                     byte_valid, byte_last, byte_data, word_count, err_underflow);
        end
        $display("reset checked");
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        enable     = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk);
        total++;
        if (fifo_rd !== 1'b1 || byte_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_first_rd: rd=%0b valid=%0b got, rd=1 valid=0 required", fifo_rd, byte_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (byte_valid !== 1'b1 || fifo_rd !== 1'b0) begin
                bad++;
                $display("FAIL basic_beat%0d: valid=%0b rd=%0b got, valid=1 rd=0 required", i, byte_valid, fifo_rd);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (byte_valid !== 1'b0 || fifo_rd !== 1'b0 || word_count !== 16'(exp_wc) || exp_wc != 1) begin
            bad++;
            $display("FAIL basic_end: valid=%0b rd=%0b wc=%0d got, valid=0 rd=0 wc=1 required",
                     byte_valid, fifo_rd, word_count);
        end
        tick();
    endtask

    task automatic test_backpressure();
        push_word(32'hDEAD_BEEF);
        @(negedge clk);
        tick();                          // read edge
        @(negedge clk);
        tick();                          // DE beat
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (byte_valid !== 1'b1 || byte_data !== 8'hAD || byte_last !== 1'b0 || fifo_rd !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: valid=%0b data=%02h last=%0b rd=%0b got, valid=1 data=ad last=0 rd=0 required",
                         i, byte_valid, byte_data, byte_last, fifo_rd);
            end
            tick();
        end
        byte_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        total++;
        if (byte_valid !== 1'b0 || word_count !== 16'(exp_wc) || exp_wc != 2 || sb_data.size() != 0) begin
            bad++;
            $display("FAIL stall_end: valid=%0b wc=%0d pending=%0d got, valid=0 wc=2 pending=0 required",
                     byte_valid, word_count, sb_data.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        push_word(32'hCAFE_BABE);
        push_word(32'h1234_5678);
        @(negedge clk);
        total++;
        if (fifo_rd !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rd0: rd=%0b got, 1 required", fifo_rd);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (byte_valid !== 1'b1 || fifo_rd !== (i == 3)) begin
                bad++;
                $display("FAIL b2b_beat%0d: valid=%0b rd=%0b got, valid=1 rd=%0b required",
                         i, byte_valid, fifo_rd, (i == 3));
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (byte_valid !== 1'b0 || word_count !== 16'(exp_wc) || exp_wc != 4) begin
            bad++;
            $display("FAIL b2b_end: valid=%0b wc=%0d got, valid=0 wc=4 required", byte_valid, word_count);
        end
        tick();
    endtask

    task automatic test_enable_drop();
        push_word(32'hCAFE_BABE);
        push_word(32'h1122_3344);
        @(negedge clk);
        tick();                          // read edge
        @(negedge clk);
        tick();                          // CA beat
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (byte_valid !== 1'b1 || fifo_rd !== 1'b0) begin
                bad++;
                $display("FAIL endrop_beat%0d: valid=%0b rd=%0b got, valid=1 rd=0 required", i, byte_valid, fifo_rd);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (byte_valid !== 1'b0 || fifo_rd !== 1'b0 || fifo_empty !== 1'b0) begin
                bad++;
                $display("FAIL endrop_idle%0d: valid=%0b rd=%0b empty=%0b got, valid=0 rd=0 empty=0 required",
                         i, byte_valid, fifo_rd, fifo_empty);
            end
            tick();
        end
        enable = 1'b1;
        @(negedge clk);
        total++;
        if (fifo_rd !== 1'b1) begin
            bad++;
            $display("FAIL endrop_resume: rd=%0b got, 1 required", fifo_rd);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        total++;
        if (byte_valid !== 1'b0 || word_count !== 16'(exp_wc) || exp_wc != 6 || sb_data.size() != 0) begin
            bad++;
            $display("FAIL endrop_end: valid=%0b wc=%0d pending=%0d got, valid=0 wc=6 pending=0 required",
                     byte_valid, word_count, sb_data.size());
        end
        tick();
    endtask

    task automatic test_underflow();
        @(negedge clk);
        total++;
        if (err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL uflow_pre: err=%0b got, 0 required", err_underflow);
        end
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        @(negedge clk);
        total++;
        if (err_underflow !== 1'b1) begin
            bad++;
            $display("FAIL uflow_set: err=%0b got, 1 required", err_underflow);
        end
        push_word(32'hA5C3_0F96);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
        end
        total++;
        if (err_underflow !== 1'b1 || word_count !== 16'(exp_wc) || exp_wc != 7 || sb_data.size() != 0) begin
            bad++;
            $display("FAIL uflow_sticky: err=%0b wc=%0d pending=%0d got, err=1 wc=7 pending=0 required",
                     err_underflow, word_count, sb_data.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_word();
        push_word(32'hCAFE_BABE);
        @(negedge clk);
        tick();                          // read edge
        @(negedge clk);
        tick();                          // CA beat
        @(negedge clk);
        tick();                          // FE beat
        @(negedge clk);
        total++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hBA) begin
            bad++;
            $display("FAIL rmid_pre: valid=%0b data=%02h got, valid=1 data=ba required", byte_valid, byte_data);
        end
        // Hold the sink off on the reset edge so no beat is taken there; the
        // rest of the word is discarded.
        rst_n      = 1'b0;
        byte_ready = 1'b0;
        enable     = 1'b0;
        tick();
        rst_n      = 1'b1;
        byte_ready = 1'b1;
        sb_data.delete();
        sb_last.delete();
        exp_wc = 0;
        @(negedge clk);
        total++;
        if (byte_valid !== 1'b0 || word_count !== 16'h0 || err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL rmid_after: valid=%0b wc=%0d err=%0b got, valid=0 wc=0 err=0 required",
                     byte_valid, word_count, err_underflow);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            total++;
            if (byte_valid !== 1'b0) begin
                bad++;
                $display("FAIL rmid_quiet%0d: valid=%0b got, 0 required", i, byte_valid);
            end
        end
        tick();
        enable = 1'b1;
        push_word(32'h0102_0304);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        total++;
        if (word_count !== 16'(exp_wc) || exp_wc != 1 || sb_data.size() != 0) begin
            bad++;
            $display("FAIL rmid_recover: wc=%0d pending=%0d got, wc=1 pending=0 required",
                     word_count, sb_data.size());
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        exp_wc         = 0;
        pop_pending    = 1'b0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        byte_ready     = 1'b0;
        fifo_underflow = 1'b0;
        refresh_fifo();
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_underflow();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
